// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-control states, default baud rate and the
// reset divisor calculation.
package uart_pkg;

  localparam int DEF_BAUD = 115200;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_IDLE = 2'd2,
    ST_RELOAD    = 2'd3
  } baud_state_e;

  // Clocks per oversample tick at DEF_BAUD, truncated.
  function automatic int def_div(input int clk_mhz, input int ovs);
    return (clk_mhz * 1000000) / (DEF_BAUD * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_ctrl.sv
// Oversample/bit tick generator for the UART TX and RX blocks. A new divisor
// is only applied between frames, via a one-cycle RELOAD state.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | ticks stopped, divisor may be written directly
// ST_RUN       | ticks running, divisor accept goes to the pending register
// ST_WAIT_IDLE | pending divisor held, ticks continue until the frame ends
// ST_RELOAD    | one cycle: pending divisor copied in, counters restarted
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter int FAST_CLK_MHZ = 100,
  parameter int OVS          = 16,
  parameter int DIV_W        = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             busy_i,
  input  logic             cfg_valid_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  output logic             cfg_ready_o,
  output logic             os_tick_o,
  output logic             bit_tick_o,
  output logic             active_o
);

  localparam int               OVS_W    = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(def_div(FAST_CLK_MHZ, OVS));
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  baud_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_reg_q, div_reg_d;
  logic [DIV_W-1:0] pend_reg_q, pend_reg_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             active_q, active_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic [DIV_W-1:0] div_in;
  logic             accept;

  assign div_in = (cfg_div_i < MIN_DIV) ? MIN_DIV : cfg_div_i;
  assign accept = cfg_valid_i & cfg_ready_q;

  always_comb begin
    state_d    = state_q;
    div_reg_d  = div_reg_q;
    pend_reg_d = pend_reg_q;
    div_cnt_d  = div_cnt_q;
    ovs_cnt_d  = ovs_cnt_q;

    // Free-running count; states below override where they restart counters.
    if (state_q == ST_RUN || state_q == ST_WAIT_IDLE) begin
      if (div_cnt_q == '0) begin
        div_cnt_d = div_reg_q - ONE;
        ovs_cnt_d = (ovs_cnt_q == OVS_LAST) ? '0 : ovs_cnt_q + OVS_W'(1);
      end else begin
        div_cnt_d = div_cnt_q - ONE;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) div_reg_d = div_in;
        if (en_i) begin
          state_d   = ST_RUN;
          div_cnt_d = (accept ? div_in : div_reg_q) - ONE;
          ovs_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d   = ST_IDLE;
          div_cnt_d = '0;
          ovs_cnt_d = '0;
        end else if (accept) begin
          pend_reg_d = div_in;
          state_d    = busy_i ? ST_WAIT_IDLE : ST_RELOAD;
        end
      end
      ST_WAIT_IDLE: begin
        if (!busy_i || !en_i) state_d = ST_RELOAD;
      end
      ST_RELOAD: begin
        div_reg_d = pend_reg_q;
        ovs_cnt_d = '0;
        if (en_i) begin
          state_d   = ST_RUN;
          div_cnt_d = pend_reg_q - ONE;
        end else begin
          state_d   = ST_IDLE;
          div_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = '0;
        ovs_cnt_d = '0;
      end
    endcase

    // Outputs are registered from next-state values so they line up with
    // the counters they describe.
    active_d    = (state_d == ST_RUN) || (state_d == ST_WAIT_IDLE);
    cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
    os_tick_d   = active_d && (div_cnt_d == '0);
    bit_tick_d  = os_tick_d && (ovs_cnt_d == OVS_LAST);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      div_reg_q   <= DEF_DIV;
      pend_reg_q  <= DEF_DIV;
      div_cnt_q   <= '0;
      ovs_cnt_q   <= '0;
      os_tick_q   <= 1'b0;
      bit_tick_q  <= 1'b0;
      active_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_reg_q   <= div_reg_d;
      pend_reg_q  <= pend_reg_d;
      div_cnt_q   <= div_cnt_d;
      ovs_cnt_q   <= ovs_cnt_d;
      os_tick_q   <= os_tick_d;
      bit_tick_q  <= bit_tick_d;
      active_q    <= active_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign cfg_ready_o = cfg_ready_q;
  assign os_tick_o   = os_tick_q;
  assign bit_tick_o  = bit_tick_q;
  assign active_o    = active_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Bench for uart_baud_ctrl: expected tick cycles are queued when stimulus is
// applied and matched against observed ticks by a monitor.
module tb_uart_baud_ctrl;

  localparam int DIV_W = 16;
  localparam int OVS   = 16;

  logic             clk_i = 1'b0;
  logic             rstn_i = 1'b0;
  logic             en_i = 1'b0;
  logic             busy_i = 1'b0;
  logic             cfg_valid_i = 1'b0;
  logic [DIV_W-1:0] cfg_div_i = '0;
  logic             cfg_ready_o;
  logic             os_tick_o;
  logic             bit_tick_o;
  logic             active_o;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int exp_os[$];
  int exp_bit[$];

  uart_baud_ctrl #(.FAST_CLK_MHZ(100), .OVS(OVS), .DIV_W(DIV_W)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .busy_i     (busy_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_div_i  (cfg_div_i),
    .cfg_ready_o(cfg_ready_o),
    .os_tick_o  (os_tick_o),
    .bit_tick_o (bit_tick_o),
    .active_o   (active_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Tick monitor: every observed tick must match the head of its queue, and
  // every queued tick must be observed on time.
  always @(negedge clk_i) begin
    if (exp_os.size() != 0 && exp_os[0] < cyc) begin
      tests_run++; fails++;
      $display("FAIL os_tick_missed: seen none, required tick at cycle %0d", exp_os[0]);
      void'(exp_os.pop_front());
    end
    if (os_tick_o) begin
      tests_run++;
      if (exp_os.size() == 0 || exp_os[0] != cyc) begin
        fails++;
        $display("FAIL os_tick_time: seen tick at cycle %0d, required next tick at %0d",
                 cyc, (exp_os.size() == 0) ? -1 : exp_os[0]);
      end else begin
        void'(exp_os.pop_front());
      end
    end
    if (exp_bit.size() != 0 && exp_bit[0] < cyc) begin
      tests_run++; fails++;
      $display("FAIL bit_tick_missed: seen none, required tick at cycle %0d", exp_bit[0]);
      void'(exp_bit.pop_front());
    end
    if (bit_tick_o) begin
      tests_run++;
      if (exp_bit.size() == 0 || exp_bit[0] != cyc) begin
        fails++;
        $display("FAIL bit_tick_time: seen tick at cycle %0d, required next tick at %0d",
                 cyc, (exp_bit.size() == 0) ? -1 : exp_bit[0]);
      end else begin
        void'(exp_bit.pop_front());
      end
    end
  end

  // n oversample ticks every d cycles after transition cycle t0; every 16th is a bit tick.
  task automatic push_ticks(input int t0, input int d, input int n);
    for (int i = 1; i <= n; i++) begin
      exp_os.push_back(t0 + d * i);
      if (i % OVS == 0) exp_bit.push_back(t0 + d * i);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_os.size() != 0 || exp_bit.size() != 0) && n < budget) begin
      step(); n++;
    end
    if (exp_os.size() != 0 || exp_bit.size() != 0) begin
      tests_run++; fails++;
      $display("FAIL drain_timeout: %0d os / %0d bit ticks outstanding, required 0",
               exp_os.size(), exp_bit.size());
      exp_os.delete(); exp_bit.delete();
    end
  endtask

  task automatic test_reset();
    int c;
    repeat (3) step();
    tests_run++;
    if ({os_tick_o, bit_tick_o, active_o} !== 3'b000) begin
      fails++; $display("FAIL reset_outputs: got %b, required 000", {os_tick_o, bit_tick_o, active_o});
    end
    rstn_i = 1'b1;
    step();
    tests_run++;
    if (cfg_ready_o !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: got %b, required 1", cfg_ready_o);
    end
    tests_run++;
    if (active_o !== 1'b0) begin
      fails++; $display("FAIL active_after_reset: got %b, required 0", active_o);
    end
    c = cyc;
    wait_cyc(c + 120);
  endtask

  task automatic test_default_rate();
    int c;
    c = cyc;
    en_i = 1'b1;
    push_ticks(c, 54, 32);
    step();
    tests_run++;
    if (active_o !== 1'b1) begin
      fails++; $display("FAIL active_in_run: got %b, required 1", active_o);
    end
    drain(54 * 32 + 100);
  endtask

  task automatic test_wait_busy();
    int c, b;
    c = cyc;
    b = c + 150;
    busy_i = 1'b1; cfg_valid_i = 1'b1; cfg_div_i = 16'd20;
    push_ticks(c - 1, 54, 2);
    push_ticks(b + 1, 20, 32);
    step();
    cfg_div_i = 16'd7;
    tests_run++;
    if (cfg_ready_o !== 1'b0) begin
      fails++; $display("FAIL ready_in_wait: got %b, required 0", cfg_ready_o);
    end
    tests_run++;
    if (active_o !== 1'b1) begin
      fails++; $display("FAIL active_in_wait: got %b, required 1", active_o);
    end
    wait_cyc(c + 100);
    tests_run++;
    if (cfg_ready_o !== 1'b0) begin
      fails++; $display("FAIL ready_held_in_wait: got %b, required 0", cfg_ready_o);
    end
    wait_cyc(b);
    cfg_valid_i = 1'b0; busy_i = 1'b0;
    step();
    tests_run++;
    if ({cfg_ready_o, active_o} !== 2'b00) begin
      fails++; $display("FAIL reload_after_busy: ready,active got %b, required 00", {cfg_ready_o, active_o});
    end
    step();
    tests_run++;
    if ({cfg_ready_o, active_o} !== 2'b11) begin
      fails++; $display("FAIL run_after_reload: ready,active got %b, required 11", {cfg_ready_o, active_o});
    end
    drain(20 * 32 + 100);
  endtask

  task automatic test_reload_fast();
    int c;
    c = cyc;
    cfg_valid_i = 1'b1; cfg_div_i = 16'd10;
    push_ticks(c + 1, 10, 32);
    step();
    cfg_valid_i = 1'b0;
    tests_run++;
    if ({cfg_ready_o, active_o} !== 2'b00) begin
      fails++; $display("FAIL reload_fast: ready,active got %b, required 00", {cfg_ready_o, active_o});
    end
    step();
    tests_run++;
    if (active_o !== 1'b1) begin
      fails++; $display("FAIL run_after_fast_reload: active got %b, required 1", active_o);
    end
    drain(10 * 32 + 100);
  endtask

  task automatic test_idle_min_div();
    int c;
    c = cyc;
    en_i = 1'b0; cfg_valid_i = 1'b1; cfg_div_i = 16'd5;
    step();
    cfg_valid_i = 1'b0;
    tests_run++;
    if ({cfg_ready_o, active_o} !== 2'b10) begin
      fails++; $display("FAIL disable_priority: ready,active got %b, required 10", {cfg_ready_o, active_o});
    end
    wait_cyc(c + 3);
    cfg_valid_i = 1'b1; cfg_div_i = 16'd0;
    step();
    cfg_valid_i = 1'b0;
    wait_cyc(c + 10);
    en_i = 1'b1;
    push_ticks(c + 10, 2, 48);
    drain(2 * 48 + 100);
  endtask

  task automatic test_wait_drop_en();
    int c;
    c = cyc;
    busy_i = 1'b1; cfg_valid_i = 1'b1; cfg_div_i = 16'd30;
    push_ticks(c - 1, 2, 3);
    step();
    cfg_valid_i = 1'b0;
    wait_cyc(c + 6);
    en_i = 1'b0;
    step();
    tests_run++;
    if ({cfg_ready_o, active_o} !== 2'b00) begin
      fails++; $display("FAIL reload_on_drop: ready,active got %b, required 00", {cfg_ready_o, active_o});
    end
    step();
    tests_run++;
    if ({cfg_ready_o, active_o} !== 2'b10) begin
      fails++; $display("FAIL idle_after_drop: ready,active got %b, required 10", {cfg_ready_o, active_o});
    end
    wait_cyc(c + 12);
    busy_i = 1'b0; en_i = 1'b1;
    push_ticks(c + 12, 30, 16);
    drain(30 * 16 + 100);
  endtask

  task automatic test_reset_mid_run();
    int c, r;
    c = cyc;
    busy_i = 1'b1; cfg_valid_i = 1'b1; cfg_div_i = 16'd40;
    step();
    cfg_valid_i = 1'b0;
    wait_cyc(c + 5);
    rstn_i = 1'b0; en_i = 1'b0; busy_i = 1'b0;
    #1;
    tests_run++;
    if ({os_tick_o, bit_tick_o, active_o} !== 3'b000) begin
      fails++; $display("FAIL async_reset_outputs: got %b, required 000", {os_tick_o, bit_tick_o, active_o});
    end
    repeat (3) step();
    rstn_i = 1'b1;
    step();
    tests_run++;
    if ({cfg_ready_o, active_o} !== 2'b10) begin
      fails++; $display("FAIL after_mid_reset: ready,active got %b, required 10", {cfg_ready_o, active_o});
    end
    r = cyc;
    wait_cyc(r + 40);
    en_i = 1'b1;
    push_ticks(r + 40, 54, 16);
    drain(54 * 16 + 100);
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_wait_busy();
    test_reload_fast();
    test_idle_min_div();
    test_wait_drop_en();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
